mac_dot_acc: RTL and testbench

- Parametrised, multi-lane successor to the team's single-lane pipelined signed MAC.
- Computes dot products of LANES signed operand pairs per beat and accumulates beats until in_last.
- Emits one result per vector over a valid/ready output with backpressure, plus a beat count.
- Sits between operand streamers and the result writeback path in the arithmetic datapath.

---
 rtl/mac_dot_acc.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mac_dot_acc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_acc.sv
// mac_dot_acc: multi-lane pipelined signed dot-product accumulator.
//
// Each accepted beat carries LANES signed operand pairs. Their products are
// summed and accumulated until the beat marked in_last. That final beat
// produces one result z, with the vector's beat count, on a valid/ready
// output port. A held result that the consumer has not taken stalls the
// whole pipeline.
//
// Pipeline (edge t = the edge that accepts the beat):
//   S1 (t)   operand register
//   S2 (t+1) per-lane full-precision signed products
//   S3 (t+2) adder-tree lane sum, sign-extended to ACC_W
//   S4 (t+3) accumulate; on last, reduce the sum to OUT_W into a result register
//   OUT(t+4) output register (z, out_cnt, ovf, out_valid)
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    operand beat handshake, in_last marks the vector end
//   a, b                 LANES packed signed operands, lane i = [i*IN_W +: IN_W]
//   out_valid/out_ready  result handshake
//   z                    signed vector result, OUT_W bits
//   out_cnt              beats in the vector, saturating
//   ovf                  result was clamped (saturating build only)
//
// Optional feature macro: MAC_DOT_ACC_SAT_EN
//   defined   : the result saturates to the OUT_W signed range, and ovf flags clamping
//   undefined : the result is the low OUT_W bits of the sum, and ovf stays 0
module mac_dot_acc #(
    parameter int IN_W  = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [LANES*IN_W-1:0] a,
    input  logic [LANES*IN_W-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      z,
    output logic [CNT_W-1:0]      out_cnt,
    output logic                  ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Pipeline state
    logic                         s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [LANES*IN_W-1:0]        s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic                         s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic signed [2*IN_W-1:0]     s2_prod_q [LANES];
    logic signed [2*IN_W-1:0]     s2_prod_d [LANES];
    logic                         s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    logic signed [ACC_W-1:0]      s3_sum_q, s3_sum_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         res_valid_q, res_valid_d, res_ovf_q, res_ovf_d;
    logic [OUT_W-1:0]             res_z_q, res_z_d;
    logic [CNT_W-1:0]             res_cnt_q, res_cnt_d;
    logic                         out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [OUT_W-1:0]             z_q, z_d;
    logic [CNT_W-1:0]             out_cnt_q, out_cnt_d;
    state_e                       state_q, state_d;

    logic                         stall, accept;
    logic signed [ACC_W-1:0]      final_sum;
    logic [CNT_W-1:0]             cnt_inc;

`ifdef MAC_DOT_ACC_SAT_EN
    // Clamp to the signed OUT_W range; result is {clamped, value}.
    function automatic logic [OUT_W:0] sat_reduce(input logic [ACC_W-1:0] v);
        logic [ACC_W-OUT_W:0] top;
        top = v[ACC_W-1:OUT_W-1];
        if ((top == '0) || (top == '1)) begin
            return {1'b0, v[OUT_W-1:0]};
        end else if (v[ACC_W-1]) begin
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction
`endif

    // A held result that is not being taken freezes every stage.
    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall && !reset;
    assign accept    = in_valid && in_ready;
    assign final_sum = acc_q + s3_sum_q;
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1'b1);

    // S1: capture the operands, and a valid marker only for accepted beats.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (!stall) begin
            s1_valid_d = accept;
            s1_last_d  = in_last;
            s1_a_d     = a;
            s1_b_d     = b;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2: full-precision signed lane products.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        for (int i = 0; i < LANES; i++) begin
            s2_prod_d[i] = s2_prod_q[i];
        end
        if (!stall) begin
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            for (int i = 0; i < LANES; i++) begin
                s2_prod_d[i] = (2*IN_W)'($signed(s1_a_q[i*IN_W +: IN_W]))
                             * (2*IN_W)'($signed(s1_b_q[i*IN_W +: IN_W]));
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // S3: lane sum, with each product sign-extended to the accumulator width.
    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_last_d  = s3_last_q;
        s3_sum_d   = s3_sum_q;
        if (!stall) begin
            s3_valid_d = s2_valid_q;
            s3_last_d  = s2_last_q;
            s3_sum_d   = '0;
            for (int i = 0; i < LANES; i++) begin
                s3_sum_d = s3_sum_d + ACC_W'(s2_prod_q[i]);
            end
        end else begin
            s3_valid_d = s3_valid_q;
        end
    end

    // S4: accumulate. A last beat emits the reduced sum and empties the accumulator.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_z_d     = res_z_q;
        res_ovf_d   = res_ovf_q;
        res_cnt_d   = res_cnt_q;
        if (stall) begin
            res_valid_d = res_valid_q;
        end else if (s3_valid_q && s3_last_q) begin
            res_valid_d = 1'b1;
`ifdef MAC_DOT_ACC_SAT_EN
            {res_ovf_d, res_z_d} = sat_reduce(final_sum);
`else
            res_z_d   = final_sum[OUT_W-1:0];
            res_ovf_d = 1'b0;
`endif
            res_cnt_d   = cnt_inc;
            acc_d       = '0;
            cnt_d       = '0;
        end else if (s3_valid_q) begin
            res_valid_d = 1'b0;
            acc_d       = final_sum;
            cnt_d       = cnt_inc;
        end else begin
            res_valid_d = 1'b0;
        end
    end

    // Output register. Without a stall, any held result is being consumed,
    // so out_valid either reloads with a new result or clears.
    always_comb begin
        out_valid_d = out_valid_q;
        z_d         = z_q;
        out_cnt_d   = out_cnt_q;
        ovf_d       = ovf_q;
        if (stall) begin
            out_valid_d = out_valid_q;
        end else if (res_valid_q) begin
            out_valid_d = 1'b1;
            z_d         = res_z_q;
            out_cnt_d   = res_cnt_q;
            ovf_d       = res_ovf_q;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Control FSM: tracks whether the accumulator is empty or filling, or whether the pipeline is held.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = stall ? ST_HOLD :
                                ((s3_valid_q && !s3_last_q) ? ST_ACCUM : ST_IDLE);
            ST_ACCUM: state_d = stall ? ST_HOLD :
                                ((s3_valid_q && s3_last_q) ? ST_IDLE : ST_ACCUM);
            ST_HOLD:  state_d = stall ? ST_HOLD :
                                ((cnt_d != '0) ? ST_ACCUM : ST_IDLE);
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s2_prod_q[i] <= '0;
            end
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_sum_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_z_q     <= '0;
            res_ovf_q   <= 1'b0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            out_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            for (int i = 0; i < LANES; i++) begin
                s2_prod_q[i] <= s2_prod_d[i];
            end
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            s3_sum_q    <= s3_sum_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_z_q     <= res_z_d;
            res_ovf_q   <= res_ovf_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            out_cnt_q   <= out_cnt_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign out_cnt   = out_cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_dot_acc.sv
// Bench for mac_dot_acc. Directed vectors are used. Expected results are
// queued when a vector's last beat is issued. A monitor pops and compares
// them on every output handshake.
module tb_mac_dot_acc;

    localparam int IN_W  = 8;
    localparam int LANES = 4;
    localparam int ACC_W = 24;
    localparam int OUT_W = 16;
    localparam int CNT_W = 8;

`ifdef MAC_DOT_ACC_SAT_EN
    localparam logic [OUT_W-1:0] Z_BIG   = 16'h7FFF;
    localparam logic             OVF_BIG = 1'b1;
`else
    localparam logic [OUT_W-1:0] Z_BIG   = 16'h0000;
    localparam logic             OVF_BIG = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_last = 1'b0;
    logic                  out_ready = 1'b1;
    logic [LANES*IN_W-1:0] a = '0;
    logic [LANES*IN_W-1:0] b = '0;
    logic                  in_ready, out_valid, ovf;
    logic [OUT_W-1:0]      z;
    logic [CNT_W-1:0]      out_cnt;

    typedef struct packed {
        logic [OUT_W-1:0] z;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ncyc = 0;
    int   last_hs = -10;
    int   run_len = 0;
    int   max_run = 0;

    always #5 clk = ~clk;

    mac_dot_acc #(
        .IN_W(IN_W), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .out_cnt(out_cnt), .ovf(ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                          input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] rep(input logic [7:0] v);
        return {4{v}};
    endfunction

    task automatic push_exp(input logic [OUT_W-1:0] ez, input logic [CNT_W-1:0] ec, input logic eo);
        exp_t e;
        e.z = ez; e.cnt = ec; e.ovf = eo;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive_beat(input logic [31:0] av, input logic [31:0] bv, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; a = av; b = bv; in_last = last;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL beat_accept: in_ready stayed 0, required 1 within 50 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor; also measures runs of back-to-back handshakes.
    always @(negedge clk) begin
        ncyc++;
        if (!reset && out_valid && out_ready) begin
            run_len = (last_hs == ncyc - 1) ? run_len + 1 : 1;
            if (run_len > max_run) max_run = run_len;
            last_hs = ncyc;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_unexpected: got z=%0h cnt=%0d, required no output", z, out_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_z", 32'(z), 32'(e.z));
                check("sb_cnt", 32'(out_cnt), 32'(e.cnt));
                check("sb_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        int k;
        // Reset state
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // One-beat vector: 5+12+21+32 = 70, output after the 4th edge past the accept edge
        push_exp(16'd70, 8'd1, 1'b0);
        drive_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk); k++;
        end
        check("latency_edges", 32'(k), 32'd5);
        @(posedge clk); #1;
        check("single_cycle_valid", 32'(out_valid), 32'd0);

        // Bubbles do not disturb the accumulation: 2 beats of 4*6 = 48, count 2
        idle(2);
        push_exp(16'd48, 8'd2, 1'b0);
        drive_beat(rep(8'd2), rep(8'd3), 1'b0);
        idle(3);
        drive_beat(rep(8'd2), rep(8'd3), 1'b1);
        idle(10);

        // Stall: three beats of 4*16384, result held while out_ready=0
        out_ready = 1'b0;
        push_exp(Z_BIG, 8'd3, OVF_BIG);
        drive_beat(rep(8'h80), rep(8'h80), 1'b0);
        drive_beat(rep(8'h80), rep(8'h80), 1'b0);
        drive_beat(rep(8'h80), rep(8'h80), 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("stall_result_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_z", 32'(z), 32'(Z_BIG));
            check("stall_out_cnt", 32'(out_cnt), 32'd3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        idle(2);

        // Back-to-back one-beat vectors: z = 4k, six consecutive handshakes
        max_run = 0;
        for (int j = 1; j <= 6; j++) begin
            push_exp(OUT_W'(4 * j), 8'd1, 1'b0);
            drive_beat(rep(8'd1), rep(8'(j)), 1'b1);
        end
        idle(10);
        check("b2b_run", 32'(max_run), 32'd6);

        // Reset after 2 of 3 beats, with a beat presented during reset
        drive_beat(rep(8'hFF), rep(8'd100), 1'b0);
        drive_beat(rep(8'hFF), rep(8'd100), 1'b0);
        in_valid = 1'b1; in_last = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_z", 32'(z), 32'd0);
        check("rst_mid_out_cnt", 32'(out_cnt), 32'd0);
        idle(10);
        push_exp(16'hFE70, 8'd1, 1'b0);
        drive_beat(rep(8'hFF), rep(8'd100), 1'b1);
        idle(10);

        // Drain
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
